// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared constants, FSM state type and address-field helpers for inst_cache
package inst_cache_types;

    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;

    typedef enum logic {IDLE, FETCH} state_e;

    // Helpers return 32-bit values; callers size them to their parameterised widths.
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned s_index);
        return (a >> OFF_W) & ((32'd1 << s_index) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned s_index);
        return a >> (OFF_W + s_index);
    endfunction

    function automatic logic [2:0] addr_word(input logic [31:0] a);
        return a[4:2];
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// inst_cache_array: W x D register array, async read, sync write-enable, async active-low clear
//   clk, rst(active-low clear), we, addr (shared read/write), wdata, rdata
module inst_cache_array #(
    parameter int W = 1,
    parameter int D = 8,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] mem_d [D];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[addr] = wdata;
        rdata = mem_q[addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '{default: '0};
        else      mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_cache.sv
// inst_cache: read-only 2-way set-associative instruction cache with single-beat line fill
//   clk, rst(async active-low)
//   fetch: inst_read, inst_addr -> inst_resp, inst_rdata (combinational on hit)
//   memory: pmem_read, pmem_address -> pmem_rdata, pmem_resp
module inst_cache
    import inst_cache_types::*;
#(
    parameter int S_INDEX = 3,
    localparam int S_TAG = 32 - OFF_W - S_INDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic [31:0]       inst_addr,
    output logic              inst_resp,
    output logic [31:0]       inst_rdata,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SETS = 1 << S_INDEX;

    state_e                   state_q, state_d;
    logic [S_TAG+S_INDEX-1:0] miss_q, miss_d;
    logic [S_TAG-1:0]         inst_tag;
    logic [S_INDEX-1:0]       inst_idx, idx;
    logic [2:0]               word;
    logic [LINE_W-1:0]        data_rd [2];
    logic [S_TAG-1:0]         tag_rd [2];
    logic [1:0]               valid_rd, hit, way_we;
    logic                     lru_rd, lru_we, lru_wd, victim, fill;

    always_comb begin
        inst_tag = S_TAG'(addr_tag(inst_addr, S_INDEX));
        inst_idx = S_INDEX'(addr_index(inst_addr, S_INDEX));
        word     = addr_word(inst_addr);
        // While filling, all arrays are addressed by the latched miss set.
        idx      = (state_q == FETCH) ? miss_q[S_INDEX-1:0] : inst_idx;
        for (int i = 0; i < 2; i++)
            hit[i] = (state_q == IDLE) && inst_read && valid_rd[i] && (tag_rd[i] == inst_tag);
        fill       = (state_q == FETCH) && pmem_resp;
        victim     = !valid_rd[0] ? 1'b0 : !valid_rd[1] ? 1'b1 : lru_rd;
        way_we     = fill ? (victim ? 2'b10 : 2'b01) : 2'b00;
        lru_we     = fill || (|hit);
        // lru names the way to replace next: the one not just used.
        lru_wd     = fill ? ~victim : hit[0];
        inst_resp  = |hit;
        inst_rdata = hit[0] ? data_rd[0][32*word +: 32] :
                     hit[1] ? data_rd[1][32*word +: 32] : '0;
        pmem_read    = (state_q == FETCH);
        pmem_address = pmem_read ? {miss_q, {OFF_W{1'b0}}} : '0;
        state_d = state_q;
        miss_d  = miss_q;
        if (state_q == IDLE && inst_read && !inst_resp) begin
            state_d = FETCH;
            miss_d  = {inst_tag, inst_idx};
        end else if (fill) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_way
        inst_cache_array #(.W(LINE_W), .D(SETS)) u_data (
            .clk, .rst, .we(way_we[g]), .addr(idx), .wdata(pmem_rdata), .rdata(data_rd[g])
        );
        inst_cache_array #(.W(S_TAG), .D(SETS)) u_tag (
            .clk, .rst, .we(way_we[g]), .addr(idx),
            .wdata(miss_q[S_TAG+S_INDEX-1:S_INDEX]), .rdata(tag_rd[g])
        );
        inst_cache_array #(.W(1), .D(SETS)) u_valid (
            .clk, .rst, .we(way_we[g]), .addr(idx), .wdata(1'b1), .rdata(valid_rd[g])
        );
    end

    inst_cache_array #(.W(1), .D(SETS)) u_lru (
        .clk, .rst, .we(lru_we), .addr(idx), .wdata(lru_wd), .rdata(lru_rd)
    );

endmodule
